mem_bus_master: RTL
===================

// Module: mem_bus_master
// PURPOSE
//  Initiator (cache-side) end of the off-chip memory handshake: rrqst/rrdy, rdrdy/rdacpt, wrqst/wacpt, shared 16-bit offdata.
//  Accepts one request per transaction from the data cache: read miss, write hit (write-through) or write miss.
//  Sequences the four-phase handshake and returns a 4-word line fill for read miss and write miss.
//  Memory side is unclocked, so rrdy/rdrdy/wacpt are synchronised before use.
// PARAMETERS
//  SYNC_STAGES  2  flops per synchroniser on rrdy, rdrdy, wacpt (min 2)
//  TIMEOUT      0  cycles allowed in any wait state before err; 0 disables watchdog
// PORTS
//  clock      in   1   system clock, rising edge
//  reset      in   1   asynchronous, active-high
//  req_valid  in   1   request strobe, sampled only when req_ready=1
//  req_type   in   2   01 READ_MISS, 10 WRITE_HIT, 11 WRITE_MISS; 00 ignored
//  req_addr   in   16  word address, latched on accept
//  req_wdata  in   16  store data, latched on accept
//  req_ready  out  1   1 in IDLE only
//  fill_valid out  1   1-cycle pulse per returned line word
//  fill_idx   out  2   word index in line (0..3) for fill_valid
//  fill_data  out  16  captured word, valid with fill_valid
//  done       out  1   1-cycle pulse at transaction end
//  err        out  1   sticky watchdog flag, cleared by reset only
//  rrqst      out  1   read request to memory
//  wrqst      out  1   write request / write-data strobe
//  rdacpt     out  1   read-data accept
//  rrdy       in   1   memory latched read address (async)
//  rdrdy      in   1   memory driving a read word (async)
//  wacpt      in   1   memory latched write address/data (async)
//  offdata    inout 16 address/data bus; driven only as stated below, else 16'hz
// BEHAVIOUR
//  Reset: IDLE; rrqst=wrqst=rdacpt=0, req_ready=1, fill_valid=done=err=0, fill_idx=0, offdata=Z, synchronisers cleared.
//  Handshake inputs are used only after SYNC_STAGES flops (suffix _s). All outputs are registered.
//  IDLE: on req_valid & req_type!=0, latch addr/wdata/type and go to ADDR.
//  ADDR: drive offdata=addr. READ_MISS: rrqst=1. WRITE_HIT: wrqst=1. WRITE_MISS: rrqst=wrqst=1.
//    Read: on rrdy_s go to R_REL. Write (either type): on wacpt_s go to W_AREL.
//  R_REL: rrqst=0, offdata=Z; on !rrdy_s go to FILL_WAIT.
//  W_AREL: rrqst=wrqst=0, offdata=Z; on !wacpt_s go to W_DATA.
//  W_DATA: offdata=wdata, wrqst=1; on wacpt_s go to W_DREL.
//  W_DREL: wrqst=0, offdata=Z; on !wacpt_s go to DONE (WRITE_HIT) or FILL_WAIT (WRITE_MISS).
//  FILL_WAIT: offdata=Z. On rdrdy_s: capture offdata, pulse fill_valid with fill_idx=cnt, rdacpt=1, go to FILL_ACK.
//  FILL_ACK: on !rdrdy_s: rdacpt=0. If cnt==3, go to DONE with cnt wrapping to 0; else cnt+1 and go to FILL_WAIT.
//  DONE: pulse done for one cycle, return to IDLE.
//  Fill order is line-aligned: word k is from {addr[15:2],k}. Exactly 4 fill_valid pulses per fill. cnt is 2 bits and wraps.
//  offdata is never driven while rdrdy_s=1 or in the FILL states (memory owns the bus). Bus contention is a bench error.
//  req_valid outside IDLE is ignored; there is no queueing.
//  Watchdog (TIMEOUT>0): a per-state counter resets on each state change. At TIMEOUT it sets err, forces IDLE and drops all strobes.
//  Async reset mid-transaction: immediate return to reset values and bus release. No partial fill_valid after reset.
//  Latency: no fixed cycle count. Each edge costs memory delay + SYNC_STAGES cycles.
// STRUCTURE
//  Package mem_bus_pkg: req_type encodings, state enum (IDLE, ADDR, R_REL, W_AREL, W_DATA, W_DREL, FILL_WAIT, FILL_ACK, DONE), LINE_WORDS=4.
//  Sub-module sync_bit (SYNC_STAGES-deep flop chain, async reset), instanced three times.
//  Top holds the FSM, cnt, watchdog and offdata tri-state.
// TESTING
//  Bench pairs the block with the off-chip Memory model (handshake2=30, mem_latency=100) and a 10 ns clock.
//  1 READ_MISS addr 16'h1235, ram[1234..1237]=A0,A1,A2,A3 -> fill_valid x4, idx 0..3, data A0..A3, then done; bus Z at end.
//  2 WRITE_HIT addr 16'h0040 data 16'hBEEF -> ram[0040]=BEEF, no fill_valid, one done, wrqst pulsed twice.
//  3 WRITE_MISS addr 16'h0102 data 16'h5A5A -> ram[0102]=5A5A, then fill of 0100..0103 with idx2=5A5A, one done.
//  4 Back-to-back READ_MISS 0x0010 then 0x0020, req_valid held high -> second accepted only after done; cnt restarts at 0.
//  5 Reset asserted during FILL_ACK of word 1 -> all outputs at reset values next edge, offdata Z, no further fill_valid.
//  6 TIMEOUT=50 with rrdy tied 0 on a READ_MISS -> err=1 after 50 cycles in ADDR, rrqst=0, req_ready=1.

Source files
------------

// File: rtl/mem_bus_pkg.sv
// Shared encodings for the cache-side off-chip memory handshake master.
// Request types, FSM state names and line geometry live here.
package mem_bus_pkg;

  localparam int LINE_WORDS = 4;
  localparam int DATA_W     = 16;

  typedef enum logic [1:0] {
    REQ_NONE       = 2'b00,
    REQ_READ_MISS  = 2'b01,
    REQ_WRITE_HIT  = 2'b10,
    REQ_WRITE_MISS = 2'b11
  } req_type_e;

  typedef enum logic [3:0] {
    IDLE,
    ADDR,
    R_REL,
    W_AREL,
    W_DATA,
    W_DREL,
    FILL_WAIT,
    FILL_ACK,
    DONE
  } state_e;

  // Bit 1 of the encoding marks a write phase, bit 0 marks a read/line fill.
  function automatic logic has_write(input req_type_e t);
    return t[1];
  endfunction

  function automatic logic has_fill(input req_type_e t);
    return t[0];
  endfunction

endpackage

// File: rtl/sync_bit.sv
// Single-bit synchroniser for an unclocked handshake input.
// STAGES flops in series, cleared by the asynchronous reset (STAGES >= 2).
module sync_bit #(
  parameter int STAGES = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] r_chain;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_chain <= '0;
    else       r_chain <= {r_chain[STAGES-2:0], d};
  end

  assign q = r_chain[STAGES-1];

endmodule

// File: rtl/mem_bus_master.sv
// Initiator side of the four-phase off-chip memory handshake: address/data
// phases on a shared tri-state bus, 4-word line fills, optional watchdog.
//
// Handshake rule: every request/strobe we raise stays high until the
// synchronised acknowledge rises, then drops, and the next phase only starts
// once the synchronised acknowledge has fallen again.
module mem_bus_master
  import mem_bus_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  input  logic [1:0]  req_type,
  input  logic [15:0] req_addr,
  input  logic [15:0] req_wdata,
  output logic        req_ready,
  output logic        fill_valid,
  output logic [1:0]  fill_idx,
  output logic [15:0] fill_data,
  output logic        done,
  output logic        err,
  output logic        rrqst,
  output logic        wrqst,
  output logic        rdacpt,
  input  logic        rrdy,
  input  logic        rdrdy,
  input  logic        wacpt,
  inout  wire  [15:0] offdata,
  output state_e      dbg_state
);

  localparam int          WD_LIM_I = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
  localparam logic [15:0] WD_LIMIT = WD_LIM_I[15:0];

  logic w_rrdy_s, w_rdrdy_s, w_wacpt_s;

  sync_bit #(.STAGES(SYNC_STAGES)) u_sync_rrdy  (.clock(clock), .reset(reset), .d(rrdy),  .q(w_rrdy_s));
  sync_bit #(.STAGES(SYNC_STAGES)) u_sync_rdrdy (.clock(clock), .reset(reset), .d(rdrdy), .q(w_rdrdy_s));
  sync_bit #(.STAGES(SYNC_STAGES)) u_sync_wacpt (.clock(clock), .reset(reset), .d(wacpt), .q(w_wacpt_s));

  state_e      r_state, w_next;
  req_type_e   r_type, w_type;
  logic [15:0] r_addr, r_wdata, w_addr;
  logic [1:0]  r_cnt;
  logic [15:0] r_wd_cnt;
  logic        w_timeout;

  logic        r_req_ready, r_fill_valid, r_done, r_err;
  logic        r_rrqst, r_wrqst, r_rdacpt, r_drv_en;
  logic [1:0]  r_fill_idx;
  logic [15:0] r_fill_data, r_drv_data;

  always_comb begin
    w_next    = r_state;
    w_timeout = 1'b0;
    w_type    = (r_state == IDLE) ? req_type_e'(req_type) : r_type;
    w_addr    = (r_state == IDLE) ? req_addr : r_addr;
    case (r_state)
      IDLE:      if (req_valid && req_type != REQ_NONE) w_next = ADDR;
      ADDR: begin
        if (has_write(r_type)) begin
          if (w_wacpt_s) w_next = W_AREL;
        end else if (w_rrdy_s) begin
          w_next = R_REL;
        end
      end
      R_REL:     if (!w_rrdy_s)  w_next = FILL_WAIT;
      W_AREL:    if (!w_wacpt_s) w_next = W_DATA;
      W_DATA:    if (w_wacpt_s)  w_next = W_DREL;
      W_DREL:    if (!w_wacpt_s) w_next = has_fill(r_type) ? FILL_WAIT : DONE;
      FILL_WAIT: if (w_rdrdy_s)  w_next = FILL_ACK;
      FILL_ACK:  if (!w_rdrdy_s) w_next = (r_cnt == 2'(LINE_WORDS - 1)) ? DONE : FILL_WAIT;
      DONE:      w_next = IDLE;
      default:   w_next = IDLE;
    endcase
    // Watchdog only fires in states that wait on the memory.
    if (TIMEOUT > 0 && w_next == r_state && r_state != IDLE && r_state != DONE &&
        r_wd_cnt == WD_LIMIT) begin
      w_next    = IDLE;
      w_timeout = 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_type       <= REQ_NONE;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_cnt        <= '0;
      r_wd_cnt     <= '0;
      r_req_ready  <= 1'b1;
      r_fill_valid <= 1'b0;
      r_fill_idx   <= '0;
      r_fill_data  <= '0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
      r_rrqst      <= 1'b0;
      r_wrqst      <= 1'b0;
      r_rdacpt     <= 1'b0;
      r_drv_en     <= 1'b0;
      r_drv_data   <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && w_next == ADDR) begin
        r_type  <= w_type;
        r_addr  <= req_addr;
        r_wdata <= req_wdata;
      end
      // Outputs are decoded from the next state so they change with it.
      r_req_ready  <= (w_next == IDLE);
      r_rrqst      <= (w_next == ADDR) && has_fill(w_type);
      r_wrqst      <= ((w_next == ADDR) && has_write(w_type)) || (w_next == W_DATA);
      r_rdacpt     <= (w_next == FILL_ACK);
      r_done       <= (w_next == DONE);
      r_fill_valid <= (r_state == FILL_WAIT) && (w_next == FILL_ACK);
      if (r_state == FILL_WAIT && w_next == FILL_ACK) begin
        r_fill_idx  <= r_cnt;
        r_fill_data <= offdata;
      end
      if (r_state == FILL_ACK && w_next != FILL_ACK) r_cnt <= r_cnt + 2'd1;
      if ((r_state == IDLE && w_next == ADDR) || w_timeout) r_cnt <= '0;
      if (w_timeout) r_err <= 1'b1;
      r_wd_cnt   <= (w_next != r_state || w_next == IDLE) ? '0 : r_wd_cnt + 16'd1;
      // The memory owns the bus whenever it is presenting read data.
      r_drv_en   <= ((w_next == ADDR) || (w_next == W_DATA)) && !w_rdrdy_s;
      r_drv_data <= (w_next == W_DATA) ? r_wdata : w_addr;
    end
  end

  assign offdata    = r_drv_en ? r_drv_data : 16'hzzzz;
  assign req_ready  = r_req_ready;
  assign fill_valid = r_fill_valid;
  assign fill_idx   = r_fill_idx;
  assign fill_data  = r_fill_data;
  assign done       = r_done;
  assign err        = r_err;
  assign rrqst      = r_rrqst;
  assign wrqst      = r_wrqst;
  assign rdacpt     = r_rdacpt;
  assign dbg_state  = r_state;

endmodule
